// File: rtl/pix_pair_packer_if.sv
// Pixel-stream input and two-pixel word output bundle of the pair packer.
// The slave modport is the packer's view; the master modport is the surrounding system's view.
interface pix_pair_packer_if #(
    parameter int ADDR_W = 19
);
    logic [23:0]       pix_in;
    logic              pix_valid;
    logic              pix_sof;
    logic              pix_ready;
    logic [35:0]       word_out;
    logic [ADDR_W-1:0] word_addr;
    logic              word_valid;
    logic              word_ready;
    logic              frame_done;
    logic              sof_err;

    modport slave (
        input  pix_in, pix_valid, pix_sof, word_ready,
        output pix_ready, word_out, word_addr, word_valid, frame_done, sof_err
    );

    modport master (
        output pix_in, pix_valid, pix_sof, word_ready,
        input  pix_ready, word_out, word_addr, word_valid, frame_done, sof_err
    );
endinterface

// File: rtl/pix_pair_packer.sv
// Truncates 24-bit RGB pixels to 18 bits, pairs them into 36-bit words with a
// linear frame word address and queues them for the frame-buffer write port.
module pix_pair_packer #(
    parameter int HPIX   = 640,
    parameter int VLINES = 480,
    parameter int ADDR_W = 19,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    pix_pair_packer_if.slave    bus
);
    localparam int                WORDS     = HPIX * VLINES / 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
    localparam int                CW        = $clog2(DEPTH + 1);
    localparam int                EW        = ADDR_W + 36;

    logic              run_r;
    logic              phase_r;
    logic              sof_err_r;
    logic              frame_done_r;
    logic [17:0]       hold_r;
    logic [ADDR_W-1:0] addr_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_n_s;
    logic [CW-1:0]     wr_idx_s;
    logic [EW-1:0]     q_r     [DEPTH];
    logic [EW-1:0]     q_n_s   [DEPTH];
    logic [EW-1:0]     sh_q_s  [DEPTH];
    logic [DEPTH-1:0]  v_r;
    logic [DEPTH-1:0]  v_n_s;
    logic [DEPTH-1:0]  sh_v_s;
    logic [EW-1:0]     new_entry_s;
    logic [17:0]       pix_trunc_s;
    logic              pix_lsb_unused_s;
    logic              pix_ready_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;

    // Keep the top six bits of every channel; the dropped LSBs are intentionally ignored.
    assign pix_trunc_s      = {bus.pix_in[23:18], bus.pix_in[15:10], bus.pix_in[7:2]};
    assign pix_lsb_unused_s = ^{bus.pix_in[17:16], bus.pix_in[9:8], bus.pix_in[1:0]};

    // run_r keeps pix_ready low through the first cycle after reset is released
    assign pix_ready_s = run_r && (count_r != CW'(DEPTH));
    assign accept_s    = bus.pix_valid && pix_ready_s;
    assign push_s      = accept_s && phase_r && !bus.pix_sof;
    assign pop_s       = v_r[0] && bus.word_ready;
    assign new_entry_s = {addr_r, pix_trunc_s, hold_r};

    assign bus.pix_ready  = pix_ready_s;
    assign bus.word_out   = q_r[0][35:0];
    assign bus.word_addr  = q_r[0][EW-1:36];
    assign bus.word_valid = v_r[0];
    assign bus.frame_done = frame_done_r;
    assign bus.sof_err    = sof_err_r;

    // Pixel pairing: phase, held even pixel, word address and SOF error flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            run_r     <= 1'b0;
            phase_r   <= 1'b0;
            hold_r    <= 18'd0;
            addr_r    <= {ADDR_W{1'b0}};
            sof_err_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
            if (accept_s) begin
                if (bus.pix_sof) begin
                    // A pending half pixel is dropped; the SOF pixel restarts word 0.
                    if (phase_r) begin
                        sof_err_r <= 1'b1;
                    end
                    hold_r  <= pix_trunc_s;
                    phase_r <= 1'b1;
                    addr_r  <= {ADDR_W{1'b0}};
                end else if (phase_r) begin
                    phase_r <= 1'b0;
                    addr_r  <= (addr_r == LAST_ADDR) ? {ADDR_W{1'b0}} : addr_r + ADDR_W'(1);
                end else begin
                    hold_r  <= pix_trunc_s;
                    phase_r <= 1'b1;
                end
            end
        end
    end

    // Shift-down FIFO next state: entry 0 is always the head, empty slots read as zero
    always_comb begin
        sh_q_s   = q_r;
        sh_v_s   = v_r;
        q_n_s    = q_r;
        v_n_s    = v_r;
        wr_idx_s = pop_s ? (count_r - CW'(1)) : count_r;
        for (int i = 0; i < DEPTH - 1; i++) begin
            sh_q_s[i] = pop_s ? q_r[i+1] : q_r[i];
            sh_v_s[i] = pop_s ? v_r[i+1] : v_r[i];
        end
        sh_q_s[DEPTH-1] = pop_s ? {EW{1'b0}} : q_r[DEPTH-1];
        sh_v_s[DEPTH-1] = pop_s ? 1'b0 : v_r[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            q_n_s[i] = (push_s && (CW'(i) == wr_idx_s)) ? new_entry_s : sh_q_s[i];
            v_n_s[i] = (push_s && (CW'(i) == wr_idx_s)) | sh_v_s[i];
        end
        case ({push_s, pop_s})
            2'b10:   count_n_s = count_r + CW'(1);
            2'b01:   count_n_s = count_r - CW'(1);
            default: count_n_s = count_r;
        endcase
    end

    // FIFO storage, occupancy and the end-of-frame pop pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_r[i] <= {EW{1'b0}};
            end
            v_r          <= {DEPTH{1'b0}};
            count_r      <= {CW{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            q_r          <= q_n_s;
            v_r          <= v_n_s;
            count_r      <= count_n_s;
            frame_done_r <= pop_s && (q_r[0][EW-1:36] == LAST_ADDR);
        end
    end
endmodule

// File: tb/tb_pix_pair_packer.sv
// Randomized and directed bench for pix_pair_packer against a queue-based model
// of the pairing, addressing, FIFO and error rules.
module tb_pix_pair_packer;
    localparam int HPIX   = 4;
    localparam int VLINES = 2;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;
    localparam int WORDS  = HPIX * VLINES / 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   fd_seen;

    pix_pair_packer_if #(.ADDR_W(ADDR_W)) bus ();

    pix_pair_packer #(
        .HPIX(HPIX), .VLINES(VLINES), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: queued words are {addr, odd, even} as plain numbers
    logic [63:0] mq[$];
    bit          pend_m;
    logic [17:0] hold_m;
    int          naddr_m;
    bit          sof_err_m;
    bit          run_m;
    bit          fd_m;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] t18(input logic [23:0] p);
        int r, g, b;
        r = int'(p) / 65536 / 4;
        g = (int'(p) / 256) % 256 / 4;
        b = int'(p) % 256 / 4;
        return 18'(r * 4096 + g * 64 + b);
    endfunction

    // One clock: check outputs against the model, drive inputs, advance model, cross the edge.
    task automatic step(input bit v, input bit s, input logic [23:0] p, input bit wr, input bit rs);
        logic [63:0] head;
        bit exp_vld, exp_rdy, acc, pop;
        exp_vld = (mq.size() != 0);
        exp_rdy = run_m && (mq.size() != DEPTH);
        head    = exp_vld ? mq[0] : 64'd0;
        check_val("word_valid", 64'(bus.word_valid), 64'(exp_vld));
        check_val("pix_ready", 64'(bus.pix_ready), 64'(exp_rdy));
        check_val("frame_done", 64'(bus.frame_done), 64'(fd_m));
        check_val("sof_err", 64'(bus.sof_err), 64'(sof_err_m));
        if (exp_vld || !run_m) begin
            check_val("word_out", 64'(bus.word_out), head % (64'd1 << 36));
            check_val("word_addr", 64'(bus.word_addr), head / (64'd1 << 36));
        end
        if (bus.frame_done) fd_seen++;

        bus.pix_valid  = v;
        bus.pix_sof    = s;
        bus.pix_in     = p;
        bus.word_ready = wr;
        reset          = rs;

        acc = v && exp_rdy;
        pop = exp_vld && wr;
        if (!rs) begin
            mq.delete();
            pend_m = 0; hold_m = 18'd0; naddr_m = 0;
            sof_err_m = 0; run_m = 0; fd_m = 0;
        end else begin
            run_m = 1;
            fd_m  = 0;
            if (pop) begin
                head = mq.pop_front();
                fd_m = ((head / (64'd1 << 36)) == 64'(WORDS - 1));
            end
            if (acc) begin
                if (s) begin
                    if (pend_m) sof_err_m = 1;
                    pend_m = 1; hold_m = t18(p); naddr_m = 0;
                end else if (pend_m) begin
                    mq.push_back(64'(naddr_m) * (64'd1 << 36) + 64'(t18(p)) * (64'd1 << 18) + 64'(hold_m));
                    naddr_m = (naddr_m + 1) % WORDS;
                    pend_m  = 0;
                end else begin
                    pend_m = 1; hold_m = t18(p);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit wr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'd0, wr, 1'b1);
    endtask

    initial begin
        logic [23:0] px;
        n_checks = 0; n_errors = 0; fd_seen = 0;
        mq.delete();
        pend_m = 0; hold_m = 18'd0; naddr_m = 0; sof_err_m = 0; run_m = 0; fd_m = 0;
        bus.pix_in = 24'd0; bus.pix_valid = 1'b0; bus.pix_sof = 1'b0; bus.word_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Reset, then the first released cycle where pix_ready must still be low
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 24'h123456, 1'b1, 1'b0);
        step(1'b1, 1'b0, 24'h123456, 1'b1, 1'b1);

        // Pair packing
        step(1'b1, 1'b1, 24'hFC0804, 1'b1, 1'b1);
        step(1'b1, 1'b0, 24'h0400FC, 1'b1, 1'b1);
        check_val("pair_word", 64'(bus.word_out), 64'({6'h01, 6'h00, 6'h3F, 6'h3F, 6'h02, 6'h01}));
        check_val("pair_addr", 64'(bus.word_addr), 64'd0);
        idle(2, 1'b1);

        // Full frame, frame_done and address wrap
        fd_seen = 0;
        step(1'b1, 1'b1, 24'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 24'($urandom), 1'b1, 1'b1);
        check_val("wrap_valid", 64'(bus.word_valid), 64'd1);
        check_val("wrap_addr", 64'(bus.word_addr), 64'd0);
        idle(3, 1'b1);
        check_val("frame_done_count", 64'(fd_seen), 64'd1);

        // Backpressure until full, then drain
        step(1'b1, 1'b1, 24'($urandom), 1'b0, 1'b1);
        for (int i = 1; i < 2 * DEPTH; i++) step(1'b1, 1'b0, 24'($urandom), 1'b0, 1'b1);
        check_val("bp_ready", 64'(bus.pix_ready), 64'd0);
        check_val("bp_head_addr", 64'(bus.word_addr), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 24'($urandom), 1'b0, 1'b1);
        idle(DEPTH + 2, 1'b1);

        // SOF in the middle of a pair
        step(1'b1, 1'b1, 24'($urandom), 1'b1, 1'b1);
        step(1'b1, 1'b0, 24'($urandom), 1'b1, 1'b1);
        step(1'b1, 1'b0, 24'($urandom), 1'b1, 1'b1);
        px = 24'($urandom);
        step(1'b1, 1'b1, px, 1'b1, 1'b1);
        step(1'b1, 1'b0, 24'($urandom), 1'b1, 1'b1);
        check_val("midsof_err", 64'(bus.sof_err), 64'd1);
        check_val("midsof_low", 64'(bus.word_out % 36'h40000), 64'(t18(px)));
        check_val("midsof_addr", 64'(bus.word_addr), 64'd0);
        idle(2, 1'b1);

        // Reset with three words queued and half a pair pending
        step(1'b1, 1'b1, 24'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 24'($urandom), 1'b0, 1'b1);
        step(1'b0, 1'b0, 24'd0, 1'b0, 1'b0);
        check_val("rst_valid", 64'(bus.word_valid), 64'd0);
        check_val("rst_sof_err", 64'(bus.sof_err), 64'd0);
        step(1'b0, 1'b0, 24'd0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 24'($urandom), 1'b0, 1'b1);
        step(1'b1, 1'b0, 24'($urandom), 1'b0, 1'b1);
        check_val("rst_next_addr", 64'(bus.word_addr), 64'd0);
        check_val("rst_next_valid", 64'(bus.word_valid), 64'd1);
        idle(DEPTH + 1, 1'b1);

        // Random traffic including simultaneous push/pop at partial fill
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, ($urandom % 16) == 0, 24'($urandom),
                 ($urandom % 3) != 0, ($urandom % 200) != 0);
        end

        for (int i = 0; i < 20 && mq.size() != 0; i++) idle(1, 1'b1);
        check_val("drained", 64'(bus.word_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
